// File: rtl/mem.sv
// rtl/mem.sv - word-organised 32-bit data memory with range/alignment error flag
//
// Purpose: data/instruction store for the sequential CPU datapath. Byte
// addresses, whole-word accesses, synchronous write, combinational read,
// synchronous active-high reset that clears every word.
//
// Ports:
//   memOut  out [31:0]       read data (0 when read=0 or access invalid)
//   address in  [ADDR_W-1:0] byte address, word index = (address-BASE)>>2
//   memIn   in  [31:0]       write data
//   clk     in               clock, all state changes on rising edge
//   read    in               read enable
//   write   in               write enable
//   reset   in               synchronous active-high reset
//   err     out              (read|write) with an invalid address
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   defined   - address[1:0]!=0 is an invalid access (err=1, write dropped,
//               memOut=0)
//   undefined - address[1:0] ignored, access goes to the containing word
module mem #(
    parameter int              DEPTH  = 1024,
    parameter int              ADDR_W = 32,
    parameter longint unsigned BASE   = 64'd0
) (
    output logic [31:0]       memOut,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       memIn,
    input  logic              clk,
    input  logic              read,
    input  logic              write,
    input  logic              reset,
    output logic              err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One past the last valid byte; compared in 64 bits so BASE+4*DEPTH
    // never wraps and the word after the last one is reliably out of range.
    localparam longint unsigned LIMIT = BASE + 64'(DEPTH) * 64'd4;

    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];
    logic [63:0]      addr_ext;
    logic             in_range;
    logic             misaligned;
    logic             access_ok;
    logic [IDX_W-1:0] word_idx;
    logic             wr_en;

    always_comb begin
        addr_ext   = 64'(address);
        in_range   = (addr_ext >= BASE) && (addr_ext < LIMIT);
`ifdef MEM_ALIGN_CHECK_EN
        misaligned = (address[1:0] != 2'b00);
`else
        misaligned = 1'b0;
`endif
        access_ok  = in_range && !misaligned;
        word_idx   = IDX_W'((addr_ext - BASE) >> 2);
        wr_en      = write && access_ok;
    end

    // Read path is purely combinational, so a simultaneous read/write shows
    // the old word until the edge and the new word afterwards (no bypass).
    always_comb begin
        memOut = 32'h0;
        if (read && access_ok) begin
            memOut = mem_q[word_idx];
        end
    end

    assign err = (read || write) && !access_ok;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[word_idx] = memIn;
        end
    end

    // Reset wins over any write issued in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: 32'h0};
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_mem.sv
// tb/tb_mem.sv - scoreboard testbench for mem
module tb_mem;

    localparam int              DEPTH = 1024;
    localparam longint unsigned BASE  = 64'd0;
    localparam longint unsigned TOP   = BASE + 64'(DEPTH) * 64'd4;

    logic        clk = 1'b0;
    logic [31:0] memOut;
    logic [31:0] address;
    logic [31:0] memIn;
    logic        read;
    logic        write;
    logic        reset;
    logic        err;

    always #5 clk = ~clk;

    mem #(.DEPTH(DEPTH), .ADDR_W(32), .BASE(BASE)) dut (
        .memOut (memOut),
        .address(address),
        .memIn  (memIn),
        .clk    (clk),
        .read   (read),
        .write  (write),
        .reset  (reset),
        .err    (err)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    bit   [31:0] model_mem [longint];
    int          checks   = 0;
    int          failures = 0;

    function automatic bit access_valid(logic [31:0] a);
        longint unsigned x;
        bit ok;
        x  = 64'(a);
        ok = (x >= BASE) && (x < TOP);
`ifdef MEM_ALIGN_CHECK_EN
        if (a % 4 != 0) ok = 1'b0;
`endif
        return ok;
    endfunction

    function automatic longint word_of(logic [31:0] a);
        return longint'((64'(a) - BASE) / 4);
    endfunction

    function automatic bit [31:0] model_read(logic [31:0] a);
        longint k;
        k = word_of(a);
        if (model_mem.exists(k)) return model_mem[k];
        return 32'h0;
    endfunction

    // Drive one cycle of stimulus, queue the expected pre-edge outputs,
    // then advance the model across the edge.
    task automatic step(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit rst, input string nm);
        exp_t e;
        bit   ok;
        read    = rd;
        write   = wr;
        address = a;
        memIn   = d;
        reset   = rst;
        ok      = access_valid(a);
        e.data  = (rd && ok) ? model_read(a) : 32'h0;
        e.err   = (rd || wr) && !ok;
        e.name  = nm;
        sb_q.push_back(e);
        @(posedge clk);
        if (rst) model_mem.delete();
        else if (wr && ok) model_mem[word_of(a)] = d;
        #1;
    endtask

    // Monitor: the DUT presents combinational outputs every cycle; sample
    // them mid-cycle and compare against the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                checks++;
                if (memOut !== e.data || err !== e.err) begin
                    failures++;
                    $display("FAIL %s addr=%h got memOut=%h err=%b expected memOut=%h err=%b",
                             e.name, address, memOut, err, e.data, e.err);
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        read = 0; write = 0; address = 0; memIn = 0; reset = 0;
        @(posedge clk); #1;

        // Reset with a concurrent write that must be discarded.
        read = 0; write = 1; address = 32'd16; memIn = 32'hffff_ffff; reset = 1;
        @(posedge clk); #1;
        model_mem.delete();
        reset = 0;

        step(0, 0, 32'd16, 0, 0, "idle_after_reset");
        step(1, 0, 32'd0,  0, 0, "rd0_after_reset");
        step(1, 0, 32'd4,  0, 0, "rd4_after_reset");
        step(1, 0, 32'd16, 0, 0, "rd16_after_reset");

        step(0, 1, 32'd16, 32'h1234_5678, 0, "wr16");
        step(0, 1, 32'd24, 32'h89ab_cdef, 0, "wr24");
        step(1, 0, 32'd16, 0, 0, "rd16");
        step(1, 0, 32'd20, 0, 0, "rd20_unwritten");
        step(1, 0, 32'd24, 0, 0, "rd24");

        step(1, 1, 32'd16, 32'hdead_beef, 0, "rw16_before_edge");
        step(1, 0, 32'd16, 0, 0, "rw16_after_edge");

        step(0, 1, 32'(TOP - 4), 32'hcafe_f00d, 0, "wr_last_word");
        step(0, 1, 32'(TOP), 32'h5555_aaaa, 0, "wr_out_of_range");
        step(1, 0, 32'(TOP), 0, 0, "rd_out_of_range");
        step(1, 0, 32'(TOP - 4), 0, 0, "rd_last_word");
        step(1, 0, 32'd0, 0, 0, "rd0_no_wrap");

        step(0, 0, 32'd16, 0, 0, "read_low");

        step(0, 1, 32'd18, 32'h0bad_0bad, 0, "wr18_misaligned");
        step(1, 0, 32'd16, 0, 0, "rd16_after_wr18");
        step(1, 0, 32'd18, 0, 0, "rd18");

        // Randomized traffic biased toward low words, the top boundary and
        // misaligned addresses, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: a = $urandom_range(0, 63);
                1: a = 32'(TOP - 8) + $urandom_range(0, 15);
                2: a = $urandom;
                default: a = $urandom_range(0, DEPTH - 1) * 4;
            endcase
            step($urandom_range(0, 1), $urandom_range(0, 1), a, $urandom,
                 ($urandom_range(0, 49) == 0), "random");
        end

        // Reset after traffic must clear previously written words.
        step(0, 1, 32'd40, 32'h1111_2222, 0, "wr40");
        step(0, 0, 32'd0, 0, 1, "reset_again");
        step(1, 0, 32'd40, 0, 0, "rd40_after_reset");

        read = 0; write = 0; reset = 0;
        @(negedge clk); #1;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
